peak_judge: RTL and testbench
=============================

Name: peak_judge

Overview:
- Downstream consumer of the 4-channel peak tracker.
- On the tracker's single-cycle done pulse, snapshots the four 12-bit channel peaks.
- Scans them sequentially, one channel per cycle, to produce:
  - the overall maximum and the winning channel,
  - the sum of the four peaks,
  - a per-channel threshold-exceed mask.
- Presents the result on a valid/ready handshake to the reporting logic.

Parameters:
- DW, 12, width of each peak value.
- CW, 8, width of the saturating drop counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- peak_1  input  DW  channel 1 peak from the tracker
- peak_2  input  DW  channel 2 peak
- peak_3  input  DW  channel 3 peak
- peak_4  input  DW  channel 4 peak
- peak_done  input  1  one-cycle strobe; peaks are valid in the same cycle
- thr  input  DW  exceed threshold, sampled with the peaks
- res_ready  input  1  downstream accepts the result
- res_valid  output  1  result available
- max_val  output  DW  largest of the four peaks
- max_ch  output  2  index of the largest peak, 0..3 = channels 1..4
- sum  output  DW+2  sum of the four peaks, no overflow possible
- over_mask  output  4  bit i set when peak_(i+1) > thr, strict comparison
- busy  output  1  state != IDLE
- drop_cnt  output  CW  count of peak_done strobes ignored while busy; saturates at all-ones

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high.
- Reset: all outputs are 0 and state is IDLE.
  - Reset mid-SCAN or mid-OUT aborts the result; res_valid is never asserted for the aborted run.
  - drop_cnt clears on reset only.
- States, one-hot:
  - IDLE:
    - peak_done=1 latches peak_1..4 and thr into snapshot registers.
    - Clears the accumulators max_val=0, max_ch=0, sum=0, over_mask=0.
    - Sets idx=0 and moves to SCAN.
  - SCAN, one channel per cycle at idx:
    - sum += snap[idx].
    - over_mask[idx] = snap[idx] > thr_snap.
    - If snap[idx] > max_val, load max_val=snap[idx] and max_ch=idx. Strict compare, so ties keep the lowest index.
    - At idx=3: move to OUT and set res_valid=1. Otherwise idx++.
  - OUT:
    - Outputs are held stable while res_valid=1.
    - On res_valid && res_ready, return to IDLE; res_valid=0 the next cycle.
    - Result outputs keep their values until the next run's IDLE→SCAN clear.
- Latency: peak_done high in cycle 0 gives res_valid high from cycle 5. With res_ready held at 1, busy spans cycles 1..5.
- Overrun:
  - peak_done while state != IDLE is dropped and drop_cnt increments, saturating at 2^CW-1.
  - This includes the OUT cycle in which the handshake completes.
  - Snapshot and result are untouched by a dropped strobe.
- Arithmetic: unsigned throughout; sum width DW+2, so 4×4095=16380 fits in 14 bits.
- peak_done held high for several cycles: the first cycle starts a run; the following cycles count as drops.

Decomposition:
- Shared package:
  - state localparams IDLE=4'b0001, SCAN=4'b0010, OUT=4'b0100 (4'b1000 reserved; illegal states recover to IDLE),
  - NCH=4,
  - index width 2.
- No sub-module: the single compare/accumulate datapath is small and shared across cycles. Keep it a flat module.

Test Plan:
- Peaks 100,900,300,50, thr=200, res_ready=1:
  - res_valid in cycle 5 for 1 cycle,
  - max_val=900, max_ch=1, sum=1350, over_mask=4'b0110.
- Tie, peaks 700,700,700,10, thr=700:
  - max_ch=0, max_val=700, sum=2110, over_mask=0000 (strict).
- All peaks 4095, thr=0: sum=16380, over_mask=1111, max_ch=0.
- Backpressure: res_ready=0 for 10 cycles after valid:
  - outputs stable, res_valid held,
  - peak_done pulsed twice during the hold gives drop_cnt=2 and an unchanged result,
  - res_ready=1 then gives IDLE next cycle.
- Reset in cycle 3 of SCAN: all outputs 0 next cycle, no res_valid. A fresh peak_done then gives a correct result.
- Saturation: 300 strobes while busy in OUT gives drop_cnt=255 with no wrap.

Source files
------------

// File: rtl/peak_judge_pkg.sv
// -----------------------------------------------------------------------------
// peak_judge_pkg
// Shared constants and types for the peak judge:
//   NCH     - number of tracker channels that are judged per run
//   IW      - width of the channel index (0..NCH-1)
//   state_t - one-hot FSM encoding; 4'b1000 is reserved, and any other
//             code is treated as illegal and recovers to IDLE
// -----------------------------------------------------------------------------
package peak_judge_pkg;

   localparam int NCH = 4;
   localparam int IW  = 2;

   typedef enum logic [3:0] {
      IDLE = 4'b0001,
      SCAN = 4'b0010,
      OUT  = 4'b0100
   } state_t;

endpackage

// File: rtl/peak_judge.sv
// -----------------------------------------------------------------------------
// peak_judge
// Consumer of the 4-channel peak tracker. A peak_done strobe in IDLE takes a
// snapshot of the four channel peaks and the threshold. The FSM then scans one
// channel per cycle, accumulating the maximum (with its channel), the sum and
// the over-threshold mask. The result is offered on a valid/ready handshake.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   peak_1..4  channel peaks, valid while peak_done is high
//   peak_done  one-cycle strobe from the tracker
//   thr        exceed threshold, sampled together with the peaks
//   res_ready  downstream accepts the result
//   res_valid  result available (held until accepted)
//   max_val    largest peak
//   max_ch     index of the largest peak (0..3 = channels 1..4), ties -> lowest
//   sum        sum of the four peaks
//   over_mask  bit i set when peak_(i+1) > thr
//   busy       FSM is not in IDLE
//   drop_cnt   peak_done strobes ignored while busy, saturating
// -----------------------------------------------------------------------------
module peak_judge
   import peak_judge_pkg::*;
#(
   parameter int DW = 12,
   parameter int CW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [DW-1:0]   peak_1,
   input  logic [DW-1:0]   peak_2,
   input  logic [DW-1:0]   peak_3,
   input  logic [DW-1:0]   peak_4,
   input  logic            peak_done,
   input  logic [DW-1:0]   thr,
   input  logic            res_ready,
   output logic            res_valid,
   output logic [DW-1:0]   max_val,
   output logic [1:0]      max_ch,
   output logic [DW+1:0]   sum,
   output logic [3:0]      over_mask,
   output logic            busy,
   output logic [CW-1:0]   drop_cnt
);

   state_t          state_reg;
   logic [IW-1:0]   idx_reg;
   logic [DW-1:0]   snap_reg [NCH];
   logic [DW-1:0]   thr_snap_reg;
   logic [DW-1:0]   peak_in [NCH];
   logic [DW-1:0]   cur_peak;
   logic            start;

   assign peak_in[0] = peak_1;
   assign peak_in[1] = peak_2;
   assign peak_in[2] = peak_3;
   assign peak_in[3] = peak_4;

   // A run only starts from IDLE; strobes in any other state are drops.
   assign start    = (state_reg == IDLE) && peak_done;
   assign cur_peak = snap_reg[idx_reg];
   assign busy     = (state_reg != IDLE);

   // Snapshot registers: written only when a run starts, so dropped strobes
   // cannot disturb the values being scanned.
   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_snap
         always_ff @(posedge clk) begin
            if (rst) begin
               snap_reg[gi] <= '0;
            end else if (start) begin
               snap_reg[gi] <= peak_in[gi];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         thr_snap_reg <= '0;
      end else if (start) begin
         thr_snap_reg <= thr;
      end
   end

   // Drop counter: counts every strobe seen outside IDLE, including the OUT
   // cycle in which the handshake completes. Cleared by reset only.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt <= '0;
      end else if (peak_done && (state_reg != IDLE) && (drop_cnt != {CW{1'b1}})) begin
         drop_cnt <= drop_cnt + CW'(1);
      end
   end

   // Control FSM and compare/accumulate datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         res_valid <= 1'b0;
         max_val   <= '0;
         max_ch    <= '0;
         sum       <= '0;
         over_mask <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               res_valid <= 1'b0;
               if (peak_done) begin
                  max_val   <= '0;
                  max_ch    <= '0;
                  sum       <= '0;
                  over_mask <= '0;
                  idx_reg   <= '0;
                  state_reg <= SCAN;
               end
            end
            SCAN: begin
               sum                <= sum + {2'b00, cur_peak};
               over_mask[idx_reg] <= (cur_peak > thr_snap_reg);
               // Strict compare keeps the lowest index on ties.
               if (cur_peak > max_val) begin
                  max_val <= cur_peak;
                  max_ch  <= idx_reg;
               end
               if (idx_reg == IW'(NCH - 1)) begin
                  res_valid <= 1'b1;
                  state_reg <= OUT;
               end else begin
                  idx_reg <= idx_reg + IW'(1);
               end
            end
            OUT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: begin
               res_valid <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_peak_judge.sv
// -----------------------------------------------------------------------------
// tb_peak_judge
// Self-checking bench for peak_judge. Each started run pushes its expected
// result onto a scoreboard queue; the entry is popped and compared when the
// DUT raises res_valid.
// -----------------------------------------------------------------------------
module tb_peak_judge;

   localparam int DW = 12;
   localparam int CW = 8;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [DW-1:0]   peak_1 = '0, peak_2 = '0, peak_3 = '0, peak_4 = '0;
   logic            peak_done = 1'b0;
   logic [DW-1:0]   thr = '0;
   logic            res_ready = 1'b0;
   logic            res_valid;
   logic [DW-1:0]   max_val;
   logic [1:0]      max_ch;
   logic [DW+1:0]   sum;
   logic [3:0]      over_mask;
   logic            busy;
   logic [CW-1:0]   drop_cnt;

   typedef struct {
      logic [DW-1:0] mv;
      logic [1:0]    mc;
      logic [DW+1:0] s;
      logic [3:0]    m;
   } res_t;

   res_t sb[$];
   int   tests_run    = 0;
   int   tests_failed = 0;
   int   exp_drop     = 0;

   peak_judge #(.DW(DW), .CW(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .peak_1    (peak_1),
      .peak_2    (peak_2),
      .peak_3    (peak_3),
      .peak_4    (peak_4),
      .peak_done (peak_done),
      .thr       (thr),
      .res_ready (res_ready),
      .res_valid (res_valid),
      .max_val   (max_val),
      .max_ch    (max_ch),
      .sum       (sum),
      .over_mask (over_mask),
      .busy      (busy),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model of one run: strict max with lowest-index ties,
   // full-width sum, strict threshold compare.
   function automatic res_t model(input logic [DW-1:0] a, b, c, d, t);
      logic [DW-1:0] p [4];
      res_t r;
      p[0] = a; p[1] = b; p[2] = c; p[3] = d;
      r.mv = '0; r.mc = '0; r.s = '0; r.m = '0;
      for (int i = 0; i < 4; i++) begin
         r.s = r.s + (DW+2)'(p[i]);
         if (p[i] > t) r.m[i] = 1'b1;
         if (p[i] > r.mv) begin
            r.mv = p[i];
            r.mc = 2'(i);
         end
      end
      return r;
   endfunction

   // Called #1 after an edge (cycle 0); returns #1 after the next edge (cycle 1).
   task automatic start_run(input logic [DW-1:0] a, b, c, d, t, input bit push);
      peak_1 = a; peak_2 = b; peak_3 = c; peak_4 = d; thr = t;
      peak_done = 1'b1;
      if (push) sb.push_back(model(a, b, c, d, t));
      @(posedge clk); #1;
      peak_done = 1'b0;
   endtask

   // Waits for res_valid; lat is the cycle number relative to the strobe.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (res_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if ({res_valid, max_val, max_ch, sum, over_mask, busy, drop_cnt} !== '0) begin
         tests_failed++;
         $display("FAIL reset_state: got valid=%b max=%0d ch=%0d sum=%0d mask=%b busy=%b drop=%0d, want all 0",
                  res_valid, max_val, max_ch, sum, over_mask, busy, drop_cnt);
      end
      rst = 1'b0;
      exp_drop = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic;
      res_t e;
      int   lat;
      res_ready = 1'b1;
      start_run(12'd100, 12'd900, 12'd300, 12'd50, 12'd200, 1'b1);
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL basic_busy_c1: got busy=%b, want 1", busy);
      end
      wait_valid(lat);
      tests_run++;
      if (lat != 5 || res_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL basic_latency: got valid in cycle %0d (valid=%b), want cycle 5", lat, res_valid);
      end
      e = sb.pop_front();
      tests_run++;
      if ({max_val, max_ch, sum, over_mask} !== {e.mv, e.mc, e.s, e.m}) begin
         tests_failed++;
         $display("FAIL basic_result: got max=%0d ch=%0d sum=%0d mask=%b, want max=%0d ch=%0d sum=%0d mask=%b",
                  max_val, max_ch, sum, over_mask, e.mv, e.mc, e.s, e.m);
      end
      $display("[TB] basic: max=%0d ch=%0d sum=%0d mask=%b", max_val, max_ch, sum, over_mask);
      @(posedge clk); #1;
      tests_run++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_one_cycle: got valid=%b busy=%b, want 0 0", res_valid, busy);
      end
   endtask

   // Shared shape for single runs with res_ready held high.
   task automatic test_single(input string name, input logic [DW-1:0] a, b, c, d, t);
      res_t e;
      int   lat;
      res_ready = 1'b1;
      start_run(a, b, c, d, t, 1'b1);
      wait_valid(lat);
      e = sb.pop_front();
      tests_run++;
      if (res_valid !== 1'b1 || {max_val, max_ch, sum, over_mask} !== {e.mv, e.mc, e.s, e.m}) begin
         tests_failed++;
         $display("FAIL %s: got valid=%b max=%0d ch=%0d sum=%0d mask=%b, want valid=1 max=%0d ch=%0d sum=%0d mask=%b",
                  name, res_valid, max_val, max_ch, sum, over_mask, e.mv, e.mc, e.s, e.m);
      end
      $display("[TB] %s: max=%0d ch=%0d sum=%0d mask=%b", name, max_val, max_ch, sum, over_mask);
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      res_t e;
      int   lat;
      res_ready = 1'b1;
      start_run(12'd5, 12'd6, 12'd7, 12'd8, 12'd6, 1'b1);
      wait_valid(lat);
      e = sb.pop_front();
      tests_run++;
      if (res_valid !== 1'b1 || {max_val, max_ch, sum, over_mask} !== {e.mv, e.mc, e.s, e.m}) begin
         tests_failed++;
         $display("FAIL b2b_first: got max=%0d ch=%0d sum=%0d mask=%b, want max=%0d ch=%0d sum=%0d mask=%b",
                  max_val, max_ch, sum, over_mask, e.mv, e.mc, e.s, e.m);
      end
      $display("[TB] b2b first: max=%0d ch=%0d sum=%0d mask=%b", max_val, max_ch, sum, over_mask);
      // Strobe held over the handshake cycle (dropped) and the IDLE cycle (starts).
      peak_1 = 12'd4000; peak_2 = 12'd1; peak_3 = 12'd4000; peak_4 = 12'd2; thr = 12'd3;
      peak_done = 1'b1;
      @(posedge clk); #1;
      exp_drop++;
      tests_run++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_idle: got valid=%b busy=%b, want 0 0", res_valid, busy);
      end
      sb.push_back(model(peak_1, peak_2, peak_3, peak_4, thr));
      @(posedge clk); #1;
      peak_done = 1'b0;
      wait_valid(lat);
      e = sb.pop_front();
      tests_run++;
      if (res_valid !== 1'b1 || {max_val, max_ch, sum, over_mask} !== {e.mv, e.mc, e.s, e.m}) begin
         tests_failed++;
         $display("FAIL b2b_second: got valid=%b max=%0d ch=%0d sum=%0d mask=%b, want max=%0d ch=%0d sum=%0d mask=%b",
                  res_valid, max_val, max_ch, sum, over_mask, e.mv, e.mc, e.s, e.m);
      end
      tests_run++;
      if (drop_cnt !== CW'(exp_drop)) begin
         tests_failed++;
         $display("FAIL b2b_drop: got drop_cnt=%0d, want %0d", drop_cnt, exp_drop);
      end
      $display("[TB] b2b second: max=%0d ch=%0d sum=%0d mask=%b drop=%0d", max_val, max_ch, sum, over_mask, drop_cnt);
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure;
      res_t e;
      int   lat;
      res_ready = 1'b0;
      start_run(12'd1234, 12'd77, 12'd2500, 12'd2500, 12'd1000, 1'b1);
      wait_valid(lat);
      e = sb.pop_front();
      for (int k = 0; k < 10; k++) begin
         if (k == 2 || k == 5) begin
            peak_1 = 12'($urandom); peak_2 = 12'($urandom);
            peak_3 = 12'($urandom); peak_4 = 12'($urandom); thr = 12'($urandom);
            peak_done = 1'b1;
         end
         @(posedge clk); #1;
         if (peak_done) exp_drop++;
         peak_done = 1'b0;
         tests_run++;
         if (res_valid !== 1'b1 || {max_val, max_ch, sum, over_mask} !== {e.mv, e.mc, e.s, e.m}) begin
            tests_failed++;
            $display("FAIL bp_hold_%0d: got valid=%b max=%0d ch=%0d sum=%0d mask=%b, want valid=1 max=%0d ch=%0d sum=%0d mask=%b",
                     k, res_valid, max_val, max_ch, sum, over_mask, e.mv, e.mc, e.s, e.m);
         end
      end
      tests_run++;
      if (drop_cnt !== CW'(exp_drop)) begin
         tests_failed++;
         $display("FAIL bp_drop: got drop_cnt=%0d, want %0d", drop_cnt, exp_drop);
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (res_valid !== 1'b0 || busy !== 1'b0 ||
          {max_val, max_ch, sum, over_mask} !== {e.mv, e.mc, e.s, e.m}) begin
         tests_failed++;
         $display("FAIL bp_release: got valid=%b busy=%b max=%0d ch=%0d sum=%0d mask=%b, want valid=0 busy=0 result kept",
                  res_valid, busy, max_val, max_ch, sum, over_mask);
      end
      $display("[TB] backpressure: max=%0d ch=%0d sum=%0d mask=%b drop=%0d", max_val, max_ch, sum, over_mask, drop_cnt);
   endtask

   task automatic test_reset_mid_scan;
      res_t e;
      int   lat;
      bit   seen_valid;
      res_ready = 1'b1;
      start_run(12'd3000, 12'd2000, 12'd1000, 12'd4000, 12'd1500, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_drop = 0;
      tests_run++;
      if ({res_valid, max_val, max_ch, sum, over_mask, busy, drop_cnt} !== '0) begin
         tests_failed++;
         $display("FAIL scan_reset: got valid=%b max=%0d ch=%0d sum=%0d mask=%b busy=%b drop=%0d, want all 0",
                  res_valid, max_val, max_ch, sum, over_mask, busy, drop_cnt);
      end
      seen_valid = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (res_valid === 1'b1) seen_valid = 1'b1;
      end
      tests_run++;
      if (seen_valid) begin
         tests_failed++;
         $display("FAIL scan_reset_abort: got res_valid=1 after abort, want 0");
      end
      start_run(12'd10, 12'd4000, 12'd20, 12'd3999, 12'd3999, 1'b1);
      wait_valid(lat);
      e = sb.pop_front();
      tests_run++;
      if (res_valid !== 1'b1 || {max_val, max_ch, sum, over_mask} !== {e.mv, e.mc, e.s, e.m}) begin
         tests_failed++;
         $display("FAIL scan_reset_fresh: got valid=%b max=%0d ch=%0d sum=%0d mask=%b, want max=%0d ch=%0d sum=%0d mask=%b",
                  res_valid, max_val, max_ch, sum, over_mask, e.mv, e.mc, e.s, e.m);
      end
      $display("[TB] reset mid-scan fresh run: max=%0d ch=%0d sum=%0d mask=%b", max_val, max_ch, sum, over_mask);
      @(posedge clk); #1;
   endtask

   task automatic test_saturation;
      res_t e;
      int   lat;
      res_ready = 1'b0;
      start_run(12'd1, 12'd2, 12'd3, 12'd4, 12'd2, 1'b1);
      wait_valid(lat);
      e = sb.pop_front();
      peak_done = 1'b1;
      repeat (300) @(posedge clk);
      #1;
      peak_done = 1'b0;
      exp_drop = (exp_drop + 300 > 255) ? 255 : exp_drop + 300;
      tests_run++;
      if (drop_cnt !== CW'(exp_drop)) begin
         tests_failed++;
         $display("FAIL sat_drop: got drop_cnt=%0d, want %0d", drop_cnt, exp_drop);
      end
      tests_run++;
      if (res_valid !== 1'b1 || {max_val, max_ch, sum, over_mask} !== {e.mv, e.mc, e.s, e.m}) begin
         tests_failed++;
         $display("FAIL sat_result: got valid=%b max=%0d ch=%0d sum=%0d mask=%b, want max=%0d ch=%0d sum=%0d mask=%b",
                  res_valid, max_val, max_ch, sum, over_mask, e.mv, e.mc, e.s, e.m);
      end
      $display("[TB] saturation: drop=%0d max=%0d ch=%0d sum=%0d mask=%b", drop_cnt, max_val, max_ch, sum, over_mask);
      res_ready = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL sat_release: got valid=%b busy=%b, want 0 0", res_valid, busy);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_single("tie", 12'd700, 12'd700, 12'd700, 12'd10, 12'd700);
      test_single("all_max", 12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd0);
      test_single("last_wins", 12'd1, 12'd2, 12'd3, 12'd4094, 12'd2);
      test_back_to_back();
      test_backpressure();
      test_reset_mid_scan();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
